seq_establish_rx: RTL and testbench

- Receive-side counterpart of the establishment handshake.
- The transmitter precedes randomized payload with a fixed 32-bit pattern word repeated N times. This block hunts for that pattern run on the incoming word stream and declares the link established after N consecutive matches.
- Once established, it asserts the receive-side randomization enable and forwards payload words.
- It drops back to hunting when the link goes quiet.

---
 rtl/seq_establish_rx.sv | 209 ++++++++++++++++++++
 tb/tb_seq_establish_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_establish_rx.sv
// -----------------------------------------------------------------------------
// seq_establish_rx
//
// This is the receive side of the link establishment handshake. Before sending
// randomized payload, the transmitter sends a fixed pattern word N times in a
// row. This block searches the incoming word stream for that run of patterns.
// After N consecutive matches it declares the link established. It then raises
// the de-randomizer enable and forwards every following valid word as payload.
// If the link stays quiet for TIMEOUT cycles, the block returns to hunting.
//
// Parameters
//   DATA_W   payload / pattern word width
//   CNT_W    width of pattern count and match counter
//   TIMEOUT  consecutive idle cycles in LOCKED before the link is lost (>= 1)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active-high
//   rx_data         incoming word
//   rx_valid        rx_data valid this cycle
//   pattern         expected establishment word (sampled while IDLE)
//   pattern_num     required consecutive pattern count N (0 treated as 1)
//   rand_en         high while LOCKED
//   est_done        one-cycle pulse on entry to LOCKED
//   link_lost       one-cycle pulse on timeout exit from LOCKED
//   match_cnt       current consecutive match count
//   data_out        forwarded payload word
//   data_out_valid  data_out valid
// -----------------------------------------------------------------------------
module seq_establish_rx #(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] pattern,
   input  logic [CNT_W-1:0]  pattern_num,
   output logic              rand_en,
   output logic              est_done,
   output logic              link_lost,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ESTABLISH = 2'd1,
      S_LOCKED    = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_match_cnt;
   logic                r_rand_en;
   logic                r_est_done;
   logic                r_link_lost;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_data_out_valid;
   logic [IDLE_W-1:0]   r_idle_cnt;
   logic [DATA_W-1:0]   r_pattern;
   logic [CNT_W-1:0]    r_neff;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_match_cnt_nxt;
   logic                w_rand_en_nxt;
   logic                w_est_done_nxt;
   logic                w_link_lost_nxt;
   logic [DATA_W-1:0]   w_data_out_nxt;
   logic                w_data_out_valid_nxt;
   logic [IDLE_W-1:0]   w_idle_cnt_nxt;
   logic [DATA_W-1:0]   w_pattern_nxt;
   logic [CNT_W-1:0]    w_neff_nxt;

   logic [CNT_W-1:0]    w_neff_in;
   logic [CNT_W-1:0]    w_match_inc;
   logic [IDLE_W-1:0]   w_idle_inc;
   logic                w_hit_live;
   logic                w_hit_latched;

   // A count of zero means "a single pattern word is enough".
   assign w_neff_in     = (pattern_num == '0) ? CNT_W'(1) : pattern_num;
   assign w_match_inc   = r_match_cnt + CNT_W'(1);
   assign w_idle_inc    = r_idle_cnt + IDLE_W'(1);
   // While IDLE, the live pattern is compared. After IDLE is left, only the
   // latched copy is used, so configuration changes made mid-handshake have
   // no effect.
   assign w_hit_live    = rx_valid && (rx_data == pattern);
   assign w_hit_latched = rx_valid && (rx_data == r_pattern);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_match_cnt      <= '0;
         r_rand_en        <= 1'b0;
         r_est_done       <= 1'b0;
         r_link_lost      <= 1'b0;
         r_data_out       <= '0;
         r_data_out_valid <= 1'b0;
         r_idle_cnt       <= '0;
         r_pattern        <= '0;
         r_neff           <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_match_cnt      <= w_match_cnt_nxt;
         r_rand_en        <= w_rand_en_nxt;
         r_est_done       <= w_est_done_nxt;
         r_link_lost      <= w_link_lost_nxt;
         r_data_out       <= w_data_out_nxt;
         r_data_out_valid <= w_data_out_valid_nxt;
         r_idle_cnt       <= w_idle_cnt_nxt;
         r_pattern        <= w_pattern_nxt;
         r_neff           <= w_neff_nxt;
      end
   end

   always_comb begin
      w_state_nxt          = r_state;
      w_match_cnt_nxt      = r_match_cnt;
      w_rand_en_nxt        = r_rand_en;
      w_est_done_nxt       = 1'b0;
      w_link_lost_nxt      = 1'b0;
      w_data_out_nxt       = r_data_out;
      w_data_out_valid_nxt = 1'b0;
      w_idle_cnt_nxt       = r_idle_cnt;
      w_pattern_nxt        = r_pattern;
      w_neff_nxt           = r_neff;

      unique case (r_state)
         S_IDLE: begin
            w_match_cnt_nxt = '0;
            w_rand_en_nxt   = 1'b0;
            w_idle_cnt_nxt  = '0;
            if (w_hit_live) begin
               w_pattern_nxt = pattern;
               w_neff_nxt    = w_neff_in;
               if (w_neff_in == CNT_W'(1)) begin
                  w_state_nxt     = S_LOCKED;
                  w_match_cnt_nxt = w_neff_in;
                  w_rand_en_nxt   = 1'b1;
                  w_est_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt     = S_ESTABLISH;
                  w_match_cnt_nxt = CNT_W'(1);
               end
            end
         end

         S_ESTABLISH: begin
            // Gaps without rx_valid simply wait here; there is no timeout.
            if (rx_valid) begin
               if (w_hit_latched) begin
                  if (w_match_inc == r_neff) begin
                     w_state_nxt     = S_LOCKED;
                     w_match_cnt_nxt = r_neff;
                     w_rand_en_nxt   = 1'b1;
                     w_est_done_nxt  = 1'b1;
                     w_idle_cnt_nxt  = '0;
                  end else begin
                     w_match_cnt_nxt = w_match_inc;
                  end
               end else begin
                  // The breaking beat is consumed here and is not treated
                  // as the first beat of a new run.
                  w_state_nxt     = S_IDLE;
                  w_match_cnt_nxt = '0;
               end
            end
         end

         S_LOCKED: begin
            if (rx_valid) begin
               // Every valid beat is payload, including pattern-valued ones.
               w_data_out_nxt       = rx_data;
               w_data_out_valid_nxt = 1'b1;
               w_idle_cnt_nxt       = '0;
            end else if (w_idle_inc == TIMEOUT_V) begin
               w_state_nxt     = S_IDLE;
               w_link_lost_nxt = 1'b1;
               w_rand_en_nxt   = 1'b0;
               w_match_cnt_nxt = '0;
               w_idle_cnt_nxt  = '0;
            end else begin
               w_idle_cnt_nxt = w_idle_inc;
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_match_cnt_nxt = '0;
            w_rand_en_nxt   = 1'b0;
            w_idle_cnt_nxt  = '0;
         end
      endcase
   end

   assign rand_en        = r_rand_en;
   assign est_done       = r_est_done;
   assign link_lost      = r_link_lost;
   assign match_cnt      = r_match_cnt;
   assign data_out       = r_data_out;
   assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_seq_establish_rx.sv
// -----------------------------------------------------------------------------
// tb_seq_establish_rx
//
// Directed testbench for seq_establish_rx with the default parameters
// (DATA_W=32, CNT_W=8, TIMEOUT=16). Each stimulus step drives the inputs,
// waits for one rising edge, and then samples the registered outputs 1 time
// unit after that edge.
// -----------------------------------------------------------------------------
module tb_seq_establish_rx;

   localparam logic [31:0] P = 32'hA5A5_5A5A;

   logic        clk;
   logic        rst;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic [31:0] pattern;
   logic [7:0]  pattern_num;
   logic        rand_en;
   logic        est_done;
   logic        link_lost;
   logic [7:0]  match_cnt;
   logic [31:0] data_out;
   logic        data_out_valid;

   int n_checks = 0;
   int n_pass   = 0;

   seq_establish_rx #(.DATA_W(32), .CNT_W(8), .TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .pattern        (pattern),
      .pattern_num    (pattern_num),
      .rand_en        (rand_en),
      .est_done       (est_done),
      .link_lost      (link_lost),
      .match_cnt      (match_cnt),
      .data_out       (data_out),
      .data_out_valid (data_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Drive one input beat, let one rising edge pass, and sample just after it.
   task automatic step(input logic v, input logic [31:0] d);
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cnt"},   32'(match_cnt),      32'd0);
      chk({tag, "_rand"},  32'(rand_en),        32'd0);
      chk({tag, "_est"},   32'(est_done),       32'd0);
      chk({tag, "_lost"},  32'(link_lost),      32'd0);
      chk({tag, "_dout"},  data_out,            32'd0);
      chk({tag, "_dv"},    32'(data_out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; pattern = P; pattern_num = 8'd4;
      #1;
      chk_all_zero("rst_init");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // IDLE: a non-matching valid beat keeps match_cnt at 0.
      step(1'b1, 32'h1234_5678); chk("idle_nomatch_cnt", 32'(match_cnt), 32'd0);

      // Basic lock with N=4.
      step(1'b1, P); chk("lk_cnt1", 32'(match_cnt), 32'd1);
      step(1'b1, P); chk("lk_cnt2", 32'(match_cnt), 32'd2);
      step(1'b1, P); chk("lk_cnt3", 32'(match_cnt), 32'd3);
                     chk("lk_est_pre", 32'(est_done), 32'd0);
      step(1'b1, P); chk("lk_est", 32'(est_done), 32'd1);
                     chk("lk_rand", 32'(rand_en), 32'd1);
                     chk("lk_cnt4", 32'(match_cnt), 32'd4);
                     chk("lk_dv_pattern", 32'(data_out_valid), 32'd0);
      step(1'b0, '0); chk("lk_est_once", 32'(est_done), 32'd0);
                     chk("lk_rand_hold", 32'(rand_en), 32'd1);

      // Payload forwarding with a 3-cycle gap between the two beats.
      step(1'b1, 32'h1111_1111); chk("pl1_dv", 32'(data_out_valid), 32'd1);
                                 chk("pl1_data", data_out, 32'h1111_1111);
      step(1'b0, '0); chk("gap_dv", 32'(data_out_valid), 32'd0);
                      chk("gap_hold", data_out, 32'h1111_1111);
      step(1'b0, '0);
      step(1'b0, '0);
      step(1'b1, 32'h2222_2222); chk("pl2_dv", 32'(data_out_valid), 32'd1);
                                 chk("pl2_data", data_out, 32'h2222_2222);
                                 chk("pl2_rand", 32'(rand_en), 32'd1);

      // 15 idle cycles, then a valid beat: the link is not lost. The beat is
      // pattern-valued and must still be forwarded as payload.
      repeat (15) step(1'b0, '0);
      step(1'b1, P); chk("nl_lost", 32'(link_lost), 32'd0);
                     chk("nl_rand", 32'(rand_en), 32'd1);
                     chk("nl_dv", 32'(data_out_valid), 32'd1);
                     chk("nl_data", data_out, P);

      // 16 idle cycles: the link times out.
      repeat (15) step(1'b0, '0);
      chk("to15_lost", 32'(link_lost), 32'd0);
      chk("to15_rand", 32'(rand_en), 32'd1);
      step(1'b0, '0); chk("to_lost", 32'(link_lost), 32'd1);
                      chk("to_rand", 32'(rand_en), 32'd0);
                      chk("to_cnt", 32'(match_cnt), 32'd0);
      step(1'b0, '0); chk("to_lost_once", 32'(link_lost), 32'd0);

      // Broken run: the bad beat returns to IDLE, and the lock needs 4 fresh beats.
      step(1'b1, P); chk("br_cnt1", 32'(match_cnt), 32'd1);
      step(1'b1, P); chk("br_cnt2", 32'(match_cnt), 32'd2);
      step(1'b1, 32'h0000_0001); chk("br_bad_cnt", 32'(match_cnt), 32'd0);
                                 chk("br_bad_rand", 32'(rand_en), 32'd0);
      step(1'b1, P); chk("br_r1", 32'(match_cnt), 32'd1);
      step(1'b1, P); chk("br_r2", 32'(match_cnt), 32'd2);
      step(1'b1, P); chk("br_r3", 32'(match_cnt), 32'd3);
                     chk("br_est_pre", 32'(est_done), 32'd0);
      step(1'b1, P); chk("br_est", 32'(est_done), 32'd1);
                     chk("br_cnt4", 32'(match_cnt), 32'd4);
      step(1'b1, 32'hCAFE_0001); chk("br_pl", data_out, 32'hCAFE_0001);

      // Reset during LOCKED: outputs clear at once, with no pulses.
      rx_valid = 1'b0;
      rst = 1'b1; #1;
      chk_all_zero("rst_lock");
      @(posedge clk); #1 rst = 1'b0;
      step(1'b0, '0); chk("rst_lock_est", 32'(est_done), 32'd0);
                      chk("rst_lock_lost", 32'(link_lost), 32'd0);

      // Reset during ESTABLISH with match_cnt=2.
      step(1'b1, P);
      step(1'b1, P); chk("re_cnt2", 32'(match_cnt), 32'd2);
      rx_valid = 1'b0;
      rst = 1'b1; #1;
      chk_all_zero("rst_est");
      @(posedge clk); #1 rst = 1'b0;
      step(1'b0, '0); chk("rst_est_est", 32'(est_done), 32'd0);

      // pattern_num=0 is treated as 1: a single beat locks.
      pattern_num = 8'd0;
      step(1'b1, P); chk("n0_est", 32'(est_done), 32'd1);
                     chk("n0_cnt", 32'(match_cnt), 32'd1);
                     chk("n0_rand", 32'(rand_en), 32'd1);
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;

      // Configuration changes during ESTABLISH are ignored.
      pattern_num = 8'd3;
      step(1'b1, P); chk("cf_cnt1", 32'(match_cnt), 32'd1);
      pattern = 32'hDEAD_BEEF; pattern_num = 8'd5;
      step(1'b1, P); chk("cf_cnt2", 32'(match_cnt), 32'd2);
      step(1'b1, P); chk("cf_est", 32'(est_done), 32'd1);
                     chk("cf_cnt3", 32'(match_cnt), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
